// File: rtl/video_pkg.sv
// Shared 640x480@60 timing constants, helpers deriving totals and sync
// windows from a timing set, and the RGB444 pixel layout.
package video_pkg;

    // Counter width for both raster coordinates.
    localparam int VGA_CNT_W = 10;

    // Clocking defaults: 100 MHz system clock, 25 MHz pixel rate.
    localparam int VGA_PIX_DIV  = 4;
    localparam int VGA_PIPE_LAT = 2;

    // Horizontal timing, in pixels.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    // Vertical timing, in lines.
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Length of a full line or frame.
    function automatic int span_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // First coordinate inside the sync pulse.
    function automatic int sync_first(int active, int fp);
        return active + fp;
    endfunction

    // Last coordinate inside the sync pulse.
    function automatic int sync_last(int active, int fp, int sync);
        return active + fp + sync - 1;
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // RGB444 as returned by the video memory: {r[11:8], g[7:4], b[3:0]}.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

endpackage

// File: rtl/scan_counter.sv
// Pixel-rate divider plus horizontal/vertical raster counters.
// The counters advance once per pixel period and wrap at the line/frame end.
module scan_counter
    import video_pkg::*;
#(
    parameter int DIV     = VGA_PIX_DIV,
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_TOTAL = VGA_V_TOTAL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 tick,
    output logic [VGA_CNT_W-1:0] h_cnt,
    output logic [VGA_CNT_W-1:0] v_cnt
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [VGA_CNT_W-1:0] H_LAST   = VGA_CNT_W'(H_TOTAL - 1);
    localparam logic [VGA_CNT_W-1:0] V_LAST   = VGA_CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] div;

    assign tick = (div == DIV_LAST);

    // Divider runs freely; raster counters step only on the last divider phase.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: drives raster coordinates to the video memory and
// realigns the returned pixel with registered sync, blanking and frame pulse.
module vga_scan_ctrl
    import video_pkg::*;
#(
    parameter int   PIX_DIV  = VGA_PIX_DIV,
    parameter int   PIPE_LAT = VGA_PIPE_LAT,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    input  logic [11:0] pixel_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank,
    output logic        frame_start
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // The pixel is sampled DIV-1 clocks after the coordinate moves, so the
    // pixel period is never allowed to drop below the memory latency + 1.
    localparam int DIV_EFF = (PIX_DIV > PIPE_LAT) ? PIX_DIV : PIPE_LAT + 1;

    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(sync_first(H_ACTIVE, H_FP));
    localparam logic [9:0] HS_LAST   = 10'(sync_last(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [9:0] VS_FIRST  = 10'(sync_first(V_ACTIVE, V_FP));
    localparam logic [9:0] VS_LAST   = 10'(sync_last(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    logic       tick;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    scan_counter #(
        .DIV     (DIV_EFF),
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt)
    );

    // Coordinates go straight out; off-screen values are fine downstream.
    assign pixel_x = h_cnt;
    assign pixel_y = v_cnt;

    rgb444_t px;
    logic    active;
    logic    in_hs;
    logic    in_vs;
    logic    at_last;

    // Decode of the current (pre-advance) raster position.
    always_comb begin
        px      = rgb444_t'(pixel_in);
        active  = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        in_hs   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        in_vs   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        at_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

    // Output alignment stage: captures colour and timing for the pixel whose
    // coordinates were presented during the period that ends on this tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && at_last;
            if (tick) begin
                vga_r  <= active ? px.r : 4'h0;
                vga_g  <= active ? px.g : 4'h0;
                vga_b  <= active ? px.b : 4'h0;
                vga_hs <= in_hs ? HS_POL : ~HS_POL;
                vga_vs <= in_vs ? VS_POL : ~VS_POL;
                vblank <= (v_cnt >= V_ACT_END);
            end
        end
    end

endmodule
